// File: rtl/vga_frame_writer_if.sv
// Frame-word stream (valid/ready/last) and display-memory write port of the
// VGA frame writer, bundled so source, writer and memories share one bundle.
interface vga_frame_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    // Incoming frame stream
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;

    // Write port towards the double-buffered display memories
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] wraddress;
    logic              wren;
    logic              memorySel;

    // Producer of frame words and consumer of the memory writes
    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, data, wraddress, wren, memorySel
    );

    // The frame writer itself
    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, data, wraddress, wren, memorySel
    );
endinterface

// File: rtl/vga_frame_writer.sv
// Writer side of the VGA controller's double-buffered display memories.
// Streams frame words (or zeros for a clear) into the selected buffer, one
// registered write per cycle, and reports completion plus frame length.
module vga_frame_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmd_clear,
    input  logic              cmd_sel,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   frame_len,
    vga_frame_writer_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CLEAR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic [ADDR_W-1:0] wraddr_q, wraddr_nxt;
    logic              wren_q, wren_nxt;
    logic              sel_q, sel_nxt;
    logic              done_nxt;
    logic [ADDR_W:0]   frame_len_nxt;
    logic              accept;

    assign bus.in_ready  = (state == LOAD);
    assign busy          = (state != IDLE);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.data      = data_q;
    assign bus.wraddress = wraddr_q;
    assign bus.wren      = wren_q;
    assign bus.memorySel = sel_q;

    // State register
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // the pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and next-value decode for the write port and status registers
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        data_nxt      = data_q;
        wraddr_nxt    = wraddr_q;
        wren_nxt      = 1'b0;
        sel_nxt       = sel_q;
        done_nxt      = 1'b0;
        frame_len_nxt = frame_len;

        unique case (state)
            IDLE: begin
                if (start || cmd_clear) begin
                    state_nxt = start ? LOAD : CLEAR;
                    sel_nxt   = cmd_sel;
                    addr_nxt  = '0;
                end
            end

            LOAD: begin
                if (accept) begin
                    data_nxt   = bus.in_data;
                    wraddr_nxt = addr;
                    wren_nxt   = 1'b1;
                    if (bus.in_last || addr == LAST_ADDR) begin
                        // Final word: the counter is left alone so it never wraps.
                        state_nxt     = IDLE;
                        done_nxt      = 1'b1;
                        frame_len_nxt = {1'b0, addr} + (ADDR_W + 1)'(1);
                    end else begin
                        addr_nxt = addr + ADDR_W'(1);
                    end
                end
            end

            CLEAR: begin
                data_nxt   = '0;
                wraddr_nxt = addr;
                wren_nxt   = 1'b1;
                if (addr == LAST_ADDR) begin
                    state_nxt     = IDLE;
                    done_nxt      = 1'b1;
                    frame_len_nxt = FULL_LEN;
                end else begin
                    addr_nxt = addr + ADDR_W'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Registered write port, address counter and completion status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr      <= '0;
            data_q    <= '0;
            wraddr_q  <= '0;
            wren_q    <= 1'b0;
            sel_q     <= 1'b0;
            done      <= 1'b0;
            frame_len <= '0;
        end else begin
            addr      <= addr_nxt;
            data_q    <= data_nxt;
            wraddr_q  <= wraddr_nxt;
            wren_q    <= wren_nxt;
            sel_q     <= sel_nxt;
            done      <= done_nxt;
            frame_len <= frame_len_nxt;
        end
    end

endmodule

// File: tb/tb_vga_frame_writer.sv
// Self-checking bench for vga_frame_writer: a write scoreboard for the long
// loads/clear, a vector table for short frames and bubbles, and hand-written
// sequences for clear timing and mid-load reset.
module tb_vga_frame_writer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            cmd_clear = 1'b0;
    logic            cmd_sel = 1'b0;
    logic            busy;
    logic            done;
    logic [ADDR_W:0] frame_len;

    vga_frame_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vga_frame_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cmd_clear (cmd_clear),
        .cmd_sel   (cmd_sel),
        .busy      (busy),
        .done      (done),
        .frame_len (frame_len),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- write scoreboard ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              sel;
        logic              done;
    } wr_t;

    wr_t sb_q[$];
    bit  sb_en = 1'b0;

    task automatic sb_push(input int a, input logic [DATA_W-1:0] d, input int sel, input int dn);
        wr_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        e.sel  = 1'(sel);
        e.done = 1'(dn);
        sb_q.push_back(e);
    endtask

    // Every write seen on the port must match the oldest expected write
    always @(negedge clk) begin
        if (sb_en && rst) begin
            if (bus.wren) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_write: got addr %0d data %0h, expected no write",
                             bus.wraddress, bus.data);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    check("sb_write{addr,data,sel,done}",
                          {bus.wraddress, bus.data, bus.memorySel, done}, e);
                end
            end else if (done) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_done_without_write: got done=1 wren=0, expected done only with wren");
            end
        end
    end

    // Drive one stream word for a cycle; push its expected write if it will be accepted
    task automatic send(input logic [DATA_W-1:0] d, input int last, input int accepted,
                        input int a, input int sel);
        if (accepted != 0) sb_push(a, d, sel, ((last != 0) || a == DEPTH - 1) ? 1 : 0);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = 1'(last);
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string             name;
        logic              start, clr, sel, valid, last;
        logic [DATA_W-1:0] din;
        logic              ready, busy, wren;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              done, msel;
        logic [ADDR_W:0]   flen;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string name, input int s, input int c, input int sl,
                           input int v, input int l, input logic [DATA_W-1:0] din,
                           input int rdy, input int bsy, input int we, input int wa,
                           input logic [DATA_W-1:0] wd, input int dn, input int ms, input int fl);
        vec_t r;
        r.name  = name;
        r.start = 1'(s);   r.clr  = 1'(c);  r.sel = 1'(sl);
        r.valid = 1'(v);   r.last = 1'(l);  r.din = din;
        r.ready = 1'(rdy); r.busy = 1'(bsy); r.wren = 1'(we);
        r.waddr = ADDR_W'(wa); r.wdata = wd;
        r.done  = 1'(dn);  r.msel = 1'(ms); r.flen = (ADDR_W + 1)'(fl);
        vq.push_back(r);
    endtask

    task automatic run_table();
        for (int k = 0; k < vq.size(); k++) begin
            start        = vq[k].start;
            cmd_clear    = vq[k].clr;
            cmd_sel      = vq[k].sel;
            bus.in_valid = vq[k].valid;
            bus.in_last  = vq[k].last;
            bus.in_data  = vq[k].din;
            @(negedge clk);
            check({vq[k].name, "_in_ready"}, bus.in_ready, vq[k].ready);
            check({vq[k].name, "_busy"}, busy, vq[k].busy);
            check({vq[k].name, "_wren"}, bus.wren, vq[k].wren);
            check({vq[k].name, "_done"}, done, vq[k].done);
            check({vq[k].name, "_memorySel"}, bus.memorySel, vq[k].msel);
            check({vq[k].name, "_frame_len"}, frame_len, vq[k].flen);
            if (vq[k].wren) begin
                check({vq[k].name, "_wraddress"}, bus.wraddress, vq[k].waddr);
                check({vq[k].name, "_data"}, bus.data, vq[k].wdata);
            end
        end
        vq.delete();
        start = 1'b0; cmd_clear = 1'b0; cmd_sel = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_j;
        int last_j;

        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;

        // ---- reset state ----
        #2;
        check("reset_wren", bus.wren, 0);
        check("reset_done", done, 0);
        check("reset_memorySel", bus.memorySel, 0);
        check("reset_frame_len", frame_len, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_wraddress", bus.wraddress, 0);
        check("reset_data", bus.data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb_en = 1'b1;

        // ---- 1: full 64-word load into memory64 ----
        start = 1'b1; cmd_sel = 1'b1;
        @(negedge clk);
        start = 1'b0; cmd_sel = 1'b0;
        check("full_in_ready_after_start", bus.in_ready, 1);
        for (int i = 0; i < DEPTH; i++) send(32'h100 + DATA_W'(i), (i == DEPTH - 1) ? 1 : 0, 1, i, 1);
        check("full_done", done, 1);
        check("full_frame_len", frame_len, 64);
        check("full_in_ready_after_end", bus.in_ready, 0);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        @(negedge clk);
        check("full_busy_after", busy, 0);
        check("full_sb_drained", sb_q.size(), 0);
        sb_en = 1'b0;

        // ---- 2: short frame of 5 words into memory32 ----
        add_vec("short_start", 1,0,0, 0,0, 32'h0,        1,1,0, 0, 32'h0,        0,0,64);
        add_vec("short_w0",    0,0,0, 1,0, 32'hA0A0_0000, 1,1,1, 0, 32'hA0A0_0000, 0,0,64);
        add_vec("short_w1",    0,0,0, 1,0, 32'hA0A0_0001, 1,1,1, 1, 32'hA0A0_0001, 0,0,64);
        add_vec("short_w2",    0,0,0, 1,0, 32'hA0A0_0002, 1,1,1, 2, 32'hA0A0_0002, 0,0,64);
        add_vec("short_w3",    0,0,0, 1,0, 32'hA0A0_0003, 1,1,1, 3, 32'hA0A0_0003, 0,0,64);
        add_vec("short_w4",    0,0,0, 1,1, 32'hA0A0_0004, 0,0,1, 4, 32'hA0A0_0004, 1,0,5);
        add_vec("short_after", 0,0,0, 1,0, 32'hDEAD_BEEF, 0,0,0, 0, 32'h0,        0,0,5);
        run_table();

        // ---- 3: bubbles, in_valid toggling every cycle ----
        add_vec("bub_start", 1,0,1, 0,0, 32'h0,        1,1,0, 0, 32'h0,        0,1,5);
        add_vec("bub_w0",    0,0,0, 1,0, 32'hB0B0_0000, 1,1,1, 0, 32'hB0B0_0000, 0,1,5);
        add_vec("bub_gap0",  0,0,0, 0,0, 32'hFFFF_FFFF, 1,1,0, 0, 32'h0,        0,1,5);
        add_vec("bub_w1",    0,0,0, 1,0, 32'hB0B0_0001, 1,1,1, 1, 32'hB0B0_0001, 0,1,5);
        add_vec("bub_gap1",  0,0,0, 0,1, 32'hFFFF_FFFF, 1,1,0, 0, 32'h0,        0,1,5);
        add_vec("bub_w2",    0,0,0, 1,0, 32'hB0B0_0002, 1,1,1, 2, 32'hB0B0_0002, 0,1,5);
        add_vec("bub_gap2",  0,0,0, 0,0, 32'hFFFF_FFFF, 1,1,0, 0, 32'h0,        0,1,5);
        add_vec("bub_w3",    0,0,0, 1,1, 32'hB0B0_0003, 0,0,1, 3, 32'hB0B0_0003, 1,1,4);
        add_vec("bub_idle",  0,0,0, 0,0, 32'h0,        0,0,0, 0, 32'h0,        0,1,4);
        run_table();

        // ---- 4: overrun, 70 words with no in_last ----
        sb_en = 1'b1;
        start = 1'b1; cmd_sel = 1'b1;
        @(negedge clk);
        start = 1'b0; cmd_sel = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i >= DEPTH) check("overrun_in_ready_low", bus.in_ready, 0);
            send(32'h4000 + DATA_W'(i), 0, (i < DEPTH) ? 1 : 0, i, 1);
        end
        check("overrun_frame_len", frame_len, 64);
        check("overrun_busy", busy, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("overrun_sb_drained", sb_q.size(), 0);

        // ---- 5: clear memory32, start during CLEAR ignored ----
        cmd_clear = 1'b1; cmd_sel = 1'b0;
        for (int i = 0; i < DEPTH; i++) sb_push(i, '0, 0, (i == DEPTH - 1) ? 1 : 0);
        @(negedge clk);
        cmd_clear = 1'b0; start = 1'b1; cmd_sel = 1'b1;
        first_j = -1;
        last_j  = -1;
        for (int j = 0; j < 70; j++) begin
            if (bus.wren) begin
                if (first_j < 0) first_j = j;
                last_j = j;
            end
            if (j == 5) check("clear_in_ready_low", bus.in_ready, 0);
            if (j == 10) begin
                start = 1'b0; cmd_sel = 1'b0;
            end
            @(negedge clk);
        end
        check("clear_first_write_cycle", first_j, 1);
        check("clear_last_write_cycle", last_j, 64);
        check("clear_busy_after", busy, 0);
        check("clear_memorySel", bus.memorySel, 0);
        check("clear_frame_len", frame_len, 64);
        check("clear_sb_drained", sb_q.size(), 0);

        // ---- 6: reset in the middle of a load ----
        start = 1'b1; cmd_sel = 1'b1;
        @(negedge clk);
        start = 1'b0; cmd_sel = 1'b0;
        for (int i = 0; i < 10; i++) send(32'h600 + DATA_W'(i), 0, 1, i, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h60A;
        #2;
        sb_en = 1'b0;
        check("midrst_sb_drained", sb_q.size(), 0);
        rst = 1'b0;
        #1;
        check("midrst_wren", bus.wren, 0);
        check("midrst_done", done, 0);
        check("midrst_memorySel", bus.memorySel, 0);
        check("midrst_frame_len", frame_len, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("after_rst_busy", busy, 0);
        check("after_rst_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_rst_no_write", bus.wren, 0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
